// File: rtl/btb_pkg.sv
// Shared BTB access definitions: port opcodes, controller states, update-entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package btb_pkg;

    // Opcode presented to the single BTB port each cycle.
    typedef enum logic [1:0] {
        BTB_NOP    = 2'd0,
        BTB_LOOKUP = 2'd1,
        BTB_WRITE  = 2'd2,
        BTB_CLEAR  = 2'd3
    } btb_op_t;

    // Access controller states.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FORCE_WR = 2'd1,
        ST_CLEAR    = 2'd2
    } ctrl_state_t;

    // Default-width update entry as seen by the execute stage and the BTB.
    localparam int BTB_W_PC_DEF  = 8;
    localparam int BTB_W_BTA_DEF = 32;

    typedef struct packed {
        logic [BTB_W_PC_DEF-1:0]  pc;
        logic [BTB_W_BTA_DEF-1:0] bta;
    } upd_entry_t;

endpackage

// File: rtl/btb_upd_queue.sv
// Coalescing update FIFO with a parallel pc-compare bypass port for lookups.
// Latency: push visible at head / bypass one cycle after the push edge; pop at the edge.
// Backpressure: push_ready low when full with no pop and no coalescing match, or while clearing.
//
// Ports: clk/reset; clear (drop all entries, block pushes); push_valid/push_pc/push_bta/push_ready;
//        pop (consume head); not_empty, head_pc, head_bta; byp_pc -> byp_hit/byp_bta.
module btb_upd_queue
    import btb_pkg::*;
#(
    parameter int W_PC   = 8,
    parameter int W_BTA  = 32,
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push_valid,
    input  logic [W_PC-1:0]  push_pc,
    input  logic [W_BTA-1:0] push_bta,
    output logic             push_ready,
    input  logic             pop,
    output logic             not_empty,
    output logic [W_PC-1:0]  head_pc,
    output logic [W_BTA-1:0] head_bta,
    input  logic [W_PC-1:0]  byp_pc,
    output logic             byp_hit,
    output logic [W_BTA-1:0] byp_bta
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t LAST = ptr_t'(QDEPTH - 1);

    logic [W_PC-1:0]  pc_q  [QDEPTH];
    logic [W_BTA-1:0] bta_q [QDEPTH];
    ptr_t             rd_ptr;
    ptr_t             wr_ptr;
    logic [CW-1:0]    count;

    logic             pop_ok;
    logic             coalesce;
    ptr_t             match_idx;
    logic             push_new;
    logic             push_upd;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LAST) ? '0 : p + ptr_t'(1);
    endfunction

    assign not_empty = (count != '0);
    assign pop_ok    = pop && not_empty;
    assign head_pc   = pc_q[rd_ptr];
    assign head_bta  = bta_q[rd_ptr];

    // Entry validity comes from the distance to the read pointer versus count,
    // so a full queue (wr_ptr == rd_ptr) needs no extra flag.
    always_comb begin
        int off;
        off       = 0;
        coalesce  = 1'b0;
        match_idx = '0;
        byp_hit   = 1'b0;
        byp_bta   = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            off = (i >= int'(rd_ptr)) ? (i - int'(rd_ptr)) : (i + QDEPTH - int'(rd_ptr));
            if (off < int'(count)) begin
                // The head leaving this cycle cannot absorb a new target.
                if ((pc_q[i] == push_pc) && !(pop_ok && (ptr_t'(i) == rd_ptr))) begin
                    coalesce  = 1'b1;
                    match_idx = ptr_t'(i);
                end
                if (pc_q[i] == byp_pc) begin
                    byp_hit = 1'b1;
                    byp_bta = bta_q[i];
                end
            end
        end
    end

    assign push_ready = !clear && (coalesce || (count < CW'(QDEPTH)) || pop_ok);
    assign push_upd   = push_valid && push_ready && coalesce;
    assign push_new   = push_valid && push_ready && !coalesce;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_new) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)   rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push_new) - CW'(pop_ok);
        end
    end

    // Payload storage needs no reset: entries are only observed through count.
    always_ff @(posedge clk) begin
        if (push_upd) begin
            bta_q[match_idx] <= push_bta;
        end else if (push_new) begin
            pc_q[wr_ptr]  <= push_pc;
            bta_q[wr_ptr] <= push_bta;
        end
    end

endmodule

// File: rtl/btb_access_ctrl.sv
// Arbitrates the single BTB port between fetch lookups, queued target updates and full clears.
// Latency: lookup response registered 1 cycle after acceptance; queued updates written when the port is free.
// Backpressure: lk_ready low during forced writes and clear; up_ready low when the queue cannot take the update.
//
// Ports: clk/reset; clear_req, flush; lk_valid/lk_pc/lk_ready -> lk_resp_valid/lk_hit/lk_bta;
//        up_valid/up_pc/up_bta/up_ready; btb_op/btb_pc/btb_wbta to the BTB, btb_hit/btb_rbta back.
module btb_access_ctrl
    import btb_pkg::*;
#(
    parameter int W_PC       = 8,
    parameter int W_BTA      = 32,
    parameter int QDEPTH     = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_req,
    input  logic             flush,
    input  logic             lk_valid,
    input  logic [W_PC-1:0]  lk_pc,
    output logic             lk_ready,
    output logic             lk_resp_valid,
    output logic             lk_hit,
    output logic [W_BTA-1:0] lk_bta,
    input  logic             up_valid,
    input  logic [W_PC-1:0]  up_pc,
    input  logic [W_BTA-1:0] up_bta,
    output logic             up_ready,
    output logic [1:0]       btb_op,
    output logic [W_PC-1:0]  btb_pc,
    output logic [W_BTA-1:0] btb_wbta,
    input  logic             btb_hit,
    input  logic [W_BTA-1:0] btb_rbta
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [SW-1:0]    starve;
    logic [SW-1:0]    starve_nxt;
    btb_op_t          op;
    logic             pop;
    logic             lk_acc;

    logic             q_not_empty;
    logic [W_PC-1:0]  q_head_pc;
    logic [W_BTA-1:0] q_head_bta;
    logic             byp_hit;
    logic [W_BTA-1:0] byp_bta;

    btb_upd_queue #(
        .W_PC   (W_PC),
        .W_BTA  (W_BTA),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_req || (state == ST_CLEAR)),
        .push_valid (up_valid),
        .push_pc    (up_pc),
        .push_bta   (up_bta),
        .push_ready (up_ready),
        .pop        (pop),
        .not_empty  (q_not_empty),
        .head_pc    (q_head_pc),
        .head_bta   (q_head_bta),
        .byp_pc     (lk_pc),
        .byp_hit    (byp_hit),
        .byp_bta    (byp_bta)
    );

    assign btb_op = op;
    assign lk_acc = lk_valid && lk_ready;

    always_comb begin
        state_nxt  = state;
        op         = BTB_NOP;
        btb_pc     = '0;
        btb_wbta   = '0;
        lk_ready   = 1'b0;
        pop        = 1'b0;
        starve_nxt = starve;

        case (state)
            ST_RUN: begin
                lk_ready = 1'b1;
                if (lk_valid) begin
                    op     = BTB_LOOKUP;
                    btb_pc = lk_pc;
                end else if (q_not_empty && !clear_req) begin
                    // A clear drops the queue this edge, so its head is never written.
                    op       = BTB_WRITE;
                    btb_pc   = q_head_pc;
                    btb_wbta = q_head_bta;
                    pop      = 1'b1;
                end
            end
            ST_FORCE_WR: begin
                if (q_not_empty && !clear_req) begin
                    op       = BTB_WRITE;
                    btb_pc   = q_head_pc;
                    btb_wbta = q_head_bta;
                    pop      = 1'b1;
                end
                state_nxt = ST_RUN;
            end
            ST_CLEAR: begin
                op        = BTB_CLEAR;
                state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase

        if (!q_not_empty || pop || clear_req) begin
            starve_nxt = '0;
        end else if (starve != SMAX) begin
            starve_nxt = starve + SW'(1);
        end

        // The cycle that loses arbitration for the STARVE_MAX-th time in a row
        // hands the next cycle to a forced write.
        if ((state == ST_RUN) && q_not_empty && !pop && !clear_req && (starve_nxt == SMAX)) begin
            state_nxt = ST_FORCE_WR;
        end

        if (clear_req) begin
            state_nxt = ST_CLEAR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_RUN;
            starve <= '0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
        end
    end

    // Queued targets are newer than the BTB contents, so they win over btb_hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lk_resp_valid <= 1'b0;
            lk_hit        <= 1'b0;
            lk_bta        <= '0;
        end else if (lk_acc && !flush) begin
            lk_resp_valid <= 1'b1;
            lk_hit        <= byp_hit || btb_hit;
            lk_bta        <= byp_hit ? byp_bta : (btb_hit ? btb_rbta : '0);
        end else begin
            lk_resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_btb_access_ctrl.sv
// Self-checking bench for btb_access_ctrl with a behavioural BTB and a response scoreboard.
// Latency: lookup responses expected exactly one cycle after acceptance.
// Backpressure: lk_ready/up_ready compared against per-cycle expectations.
module tb_btb_access_ctrl;

    localparam bit [1:0] NOP = 2'd0;
    localparam bit [1:0] LK  = 2'd1;
    localparam bit [1:0] WR  = 2'd2;
    localparam bit [1:0] CL  = 2'd3;

    logic        clk;
    logic        reset;
    logic        clear_req;
    logic        flush;
    logic        lk_valid;
    logic [7:0]  lk_pc;
    logic        lk_ready;
    logic        lk_resp_valid;
    logic        lk_hit;
    logic [31:0] lk_bta;
    logic        up_valid;
    logic [7:0]  up_pc;
    logic [31:0] up_bta;
    logic        up_ready;
    logic [1:0]  btb_op;
    logic [7:0]  btb_pc;
    logic [31:0] btb_wbta;
    logic        btb_hit;
    logic [31:0] btb_rbta;

    btb_access_ctrl #(
        .W_PC       (8),
        .W_BTA      (32),
        .QDEPTH     (2),
        .STARVE_MAX (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear_req     (clear_req),
        .flush         (flush),
        .lk_valid      (lk_valid),
        .lk_pc         (lk_pc),
        .lk_ready      (lk_ready),
        .lk_resp_valid (lk_resp_valid),
        .lk_hit        (lk_hit),
        .lk_bta        (lk_bta),
        .up_valid      (up_valid),
        .up_pc         (up_pc),
        .up_bta        (up_bta),
        .up_ready      (up_ready),
        .btb_op        (btb_op),
        .btb_pc        (btb_pc),
        .btb_wbta      (btb_wbta),
        .btb_hit       (btb_hit),
        .btb_rbta      (btb_rbta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BTB: combinational read, write/clear on the rising edge.
    bit        mv [256];
    bit [31:0] mt [256];
    bit        mclr;

    always @(posedge clk) begin
        if (mclr || btb_op == CL) begin
            for (int i = 0; i < 256; i++) mv[i] <= 1'b0;
        end else if (btb_op == WR) begin
            mv[btb_pc] <= 1'b1;
            mt[btb_pc] <= btb_wbta;
        end
    end

    assign btb_hit  = mv[btb_pc];
    assign btb_rbta = mv[btb_pc] ? mt[btb_pc] : 32'h0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, longint unsigned act, longint unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    typedef struct {
        bit        hit;
        bit [31:0] bta;
        int        stamp;
    } exp_t;

    exp_t sb[$];

    function automatic void expect_resp(bit hit, bit [31:0] bta);
        exp_t e;
        e.hit   = hit;
        e.bta   = bta;
        e.stamp = cyc + 1;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].stamp < cyc) begin
            chk("resp_missing", 0, 1);
            void'(sb.pop_front());
        end
        if (lk_resp_valid) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_cycle", longint'(cyc), longint'(e.stamp));
                chk("resp_hit", lk_hit, e.hit);
                chk("resp_bta", lk_bta, e.bta);
            end
        end
    end

    typedef struct {
        bit        lv;
        bit [7:0]  lpc;
        bit        uv;
        bit [7:0]  upc;
        bit [31:0] ubta;
        bit        fl;
        bit        clr;
        bit        e_lkr;
        bit        e_upr;
        bit [1:0]  e_op;
        bit [7:0]  e_pc;
        bit [31:0] e_wbta;
        bit        e_rsp;
        bit        e_hit;
        bit [31:0] e_bta;
    } vec_t;

    function automatic vec_t V(bit lv, bit [7:0] lpc, bit uv, bit [7:0] upc, bit [31:0] ubta,
                               bit fl, bit clr, bit e_lkr, bit e_upr, bit [1:0] e_op,
                               bit [7:0] e_pc, bit [31:0] e_wbta, bit e_rsp, bit e_hit,
                               bit [31:0] e_bta);
        vec_t v;
        v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ubta = ubta;
        v.fl = fl; v.clr = clr; v.e_lkr = e_lkr; v.e_upr = e_upr; v.e_op = e_op;
        v.e_pc = e_pc; v.e_wbta = e_wbta; v.e_rsp = e_rsp; v.e_hit = e_hit; v.e_bta = e_bta;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lk_valid  = 1'b0;
        lk_pc     = 8'h00;
        up_valid  = 1'b0;
        up_pc     = 8'h00;
        up_bta    = 32'h0;
        flush     = 1'b0;
        clear_req = 1'b0;
    endtask

    vec_t vt[$];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        lv lpc   uv upc  ubta  fl clr lkr upr op   pc    wbta  rsp hit bta
        vt.push_back(V(0, 8'h00, 1, 8'h08, 32'h11, 0, 0, 1, 1, NOP, 8'h00, 32'h00, 0, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 0, 8'h00, 32'h00, 0, 0, 1, 1, WR,  8'h08, 32'h11, 0, 0, 32'h00));
        vt.push_back(V(1, 8'h08, 0, 8'h00, 32'h00, 0, 0, 1, 1, LK,  8'h08, 32'h00, 1, 1, 32'h11));
        vt.push_back(V(0, 8'h00, 1, 8'h12, 32'h22, 0, 0, 1, 1, NOP, 8'h00, 32'h00, 0, 0, 32'h00));
        vt.push_back(V(1, 8'h12, 0, 8'h00, 32'h00, 0, 0, 1, 1, LK,  8'h12, 32'h00, 1, 1, 32'h22));
        vt.push_back(V(1, 8'h07, 0, 8'h00, 32'h00, 0, 0, 1, 1, LK,  8'h07, 32'h00, 1, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 0, 8'h00, 32'h00, 0, 0, 1, 1, WR,  8'h12, 32'h22, 0, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 1, 8'h30, 32'h01, 0, 0, 1, 1, NOP, 8'h00, 32'h00, 0, 0, 32'h00));
        vt.push_back(V(1, 8'h08, 1, 8'h31, 32'h02, 0, 0, 1, 1, LK,  8'h08, 32'h00, 1, 1, 32'h11));
        vt.push_back(V(1, 8'h08, 1, 8'h32, 32'h03, 0, 0, 1, 0, LK,  8'h08, 32'h00, 1, 1, 32'h11));
        vt.push_back(V(1, 8'h08, 1, 8'h31, 32'h99, 0, 0, 1, 1, LK,  8'h08, 32'h00, 1, 1, 32'h11));
        vt.push_back(V(1, 8'h31, 1, 8'h33, 32'h04, 0, 0, 0, 1, WR,  8'h30, 32'h01, 0, 0, 32'h00));
        vt.push_back(V(1, 8'h31, 0, 8'h00, 32'h00, 0, 0, 1, 0, LK,  8'h31, 32'h00, 1, 1, 32'h99));
        vt.push_back(V(0, 8'h00, 0, 8'h00, 32'h00, 0, 0, 1, 1, WR,  8'h31, 32'h99, 0, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 0, 8'h00, 32'h00, 0, 0, 1, 1, WR,  8'h33, 32'h04, 0, 0, 32'h00));
        vt.push_back(V(1, 8'h31, 0, 8'h00, 32'h00, 0, 0, 1, 1, LK,  8'h31, 32'h00, 1, 1, 32'h99));
        vt.push_back(V(1, 8'h33, 0, 8'h00, 32'h00, 1, 0, 1, 1, LK,  8'h33, 32'h00, 0, 0, 32'h00));
        vt.push_back(V(1, 8'h33, 0, 8'h00, 32'h00, 0, 0, 1, 1, LK,  8'h33, 32'h00, 1, 1, 32'h04));
        vt.push_back(V(0, 8'h00, 1, 8'h40, 32'h05, 0, 0, 1, 1, NOP, 8'h00, 32'h00, 0, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 1, 8'h40, 32'h06, 0, 0, 1, 1, WR,  8'h40, 32'h05, 0, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 0, 8'h00, 32'h00, 0, 0, 1, 1, WR,  8'h40, 32'h06, 0, 0, 32'h00));
        vt.push_back(V(1, 8'h40, 0, 8'h00, 32'h00, 0, 0, 1, 1, LK,  8'h40, 32'h00, 1, 1, 32'h06));
        vt.push_back(V(1, 8'h50, 1, 8'h50, 32'h07, 0, 0, 1, 1, LK,  8'h50, 32'h00, 1, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 0, 8'h00, 32'h00, 0, 0, 1, 1, WR,  8'h50, 32'h07, 0, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 1, 8'h60, 32'h08, 0, 0, 1, 1, NOP, 8'h00, 32'h00, 0, 0, 32'h00));
        vt.push_back(V(1, 8'h08, 1, 8'h61, 32'h09, 0, 0, 1, 1, LK,  8'h08, 32'h00, 1, 1, 32'h11));
        vt.push_back(V(1, 8'h60, 1, 8'h62, 32'h0a, 0, 1, 1, 0, LK,  8'h60, 32'h00, 1, 1, 32'h08));
        vt.push_back(V(1, 8'h08, 1, 8'h63, 32'h0b, 0, 0, 0, 0, CL,  8'h00, 32'h00, 0, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 0, 8'h00, 32'h00, 0, 0, 1, 1, NOP, 8'h00, 32'h00, 0, 0, 32'h00));
        vt.push_back(V(1, 8'h08, 0, 8'h00, 32'h00, 0, 0, 1, 1, LK,  8'h08, 32'h00, 1, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 0, 8'h00, 32'h00, 0, 1, 1, 0, NOP, 8'h00, 32'h00, 0, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 0, 8'h00, 32'h00, 0, 0, 0, 0, CL,  8'h00, 32'h00, 0, 0, 32'h00));
        vt.push_back(V(0, 8'h00, 0, 8'h00, 32'h00, 0, 0, 1, 1, NOP, 8'h00, 32'h00, 0, 0, 32'h00));

        // Reset
        idle_inputs();
        mclr  = 1'b1;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step();
        step();
        chk("rst_resp_valid", lk_resp_valid, 0);
        chk("rst_hit", lk_hit, 0);
        chk("rst_bta", lk_bta, 0);
        chk("rst_op", btb_op, NOP);
        chk("rst_btb_pc", btb_pc, 0);
        chk("rst_wbta", btb_wbta, 0);
        chk("rst_lk_ready", lk_ready, 1);
        chk("rst_up_ready", up_ready, 1);
        reset = 1'b1;
        mclr  = 1'b0;

        // Table-driven cycles
        foreach (vt[i]) begin
            lk_valid  = vt[i].lv;
            lk_pc     = vt[i].lpc;
            up_valid  = vt[i].uv;
            up_pc     = vt[i].upc;
            up_bta    = vt[i].ubta;
            flush     = vt[i].fl;
            clear_req = vt[i].clr;
            #2;
            chk($sformatf("v%0d_lk_ready", i), lk_ready, vt[i].e_lkr);
            chk($sformatf("v%0d_up_ready", i), up_ready, vt[i].e_upr);
            chk($sformatf("v%0d_op", i), btb_op, vt[i].e_op);
            chk($sformatf("v%0d_btb_pc", i), btb_pc, vt[i].e_pc);
            if (vt[i].e_op == WR) chk($sformatf("v%0d_wbta", i), btb_wbta, vt[i].e_wbta);
            if (vt[i].e_rsp) expect_resp(vt[i].e_hit, vt[i].e_bta);
            step();
        end
        idle_inputs();
        step();

        // Starvation: one queued entry under continuous lookups forces a write in cycle 4
        for (int k = 0; k < 7; k++) begin
            lk_valid = 1'b1;
            lk_pc    = 8'h01;
            up_valid = (k == 0);
            up_pc    = 8'h70;
            up_bta   = 32'h0b;
            #2;
            chk($sformatf("starve%0d_lk_ready", k), lk_ready, (k != 4));
            chk($sformatf("starve%0d_op", k), btb_op, (k == 4) ? WR : LK);
            if (k == 4) begin
                chk("starve_wr_pc", btb_pc, 8'h70);
                chk("starve_wr_bta", btb_wbta, 32'h0b);
            end else begin
                expect_resp(1'b0, 32'h0);
            end
            step();
        end
        idle_inputs();
        step();

        // Flush: response suppressed, previous hit/bta held
        lk_valid = 1'b1;
        lk_pc    = 8'h70;
        expect_resp(1'b1, 32'h0b);
        step();
        lk_pc = 8'h08;
        flush = 1'b1;
        step();
        idle_inputs();
        #2;
        chk("flush_resp_valid", lk_resp_valid, 0);
        chk("flush_hold_hit", lk_hit, 1);
        chk("flush_hold_bta", lk_bta, 32'h0b);
        step();
        #2;
        chk("idle_resp_valid", lk_resp_valid, 0);
        chk("idle_hold_bta", lk_bta, 32'h0b);
        step();

        // Async reset with two queued entries: contents lost, no WRITE or CLEAR afterwards
        lk_valid = 1'b1;
        lk_pc    = 8'h01;
        up_valid = 1'b1;
        up_pc    = 8'h80;
        up_bta   = 32'h0c;
        expect_resp(1'b0, 32'h0);
        step();
        up_pc  = 8'h81;
        up_bta = 32'h0d;
        expect_resp(1'b0, 32'h0);
        step();
        up_valid = 1'b0;
        #2;
        chk("prerst_op", btb_op, LK);
        @(negedge clk);
        #2;
        reset    = 1'b0;
        lk_valid = 1'b0;
        #1;
        chk("arst_resp_valid", lk_resp_valid, 0);
        chk("arst_hit", lk_hit, 0);
        chk("arst_bta", lk_bta, 0);
        chk("arst_op", btb_op, NOP);
        chk("arst_btb_pc", btb_pc, 0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("postrst%0d_op", k), btb_op, NOP);
            chk($sformatf("postrst%0d_up_ready", k), up_ready, 1);
            step();
        end
        lk_valid = 1'b1;
        lk_pc    = 8'h80;
        expect_resp(1'b0, 32'h0);
        step();
        idle_inputs();
        step();
        step();
        step();

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_access_ctrl.md
Name: btb_access_ctrl

Overview:
Sequences all accesses to the single-ported branch target buffer. It shares the BTB port between fetch-stage lookups and execute-stage target updates, buffering updates in a small coalescing queue. It forwards queued, not-yet-written targets to lookups and runs a full clear on request. It sits between the fetch/execute stages and the BTB; the BTB does a combinational lookup and writes on the clock edge.

Parameters:
W_PC, 8, width of the PC tag used to index/tag the BTB
W_BTA, 32, width of a branch target address
QDEPTH, 2, update-queue depth (entries); must be >= 1
STARVE_MAX, 3, consecutive cycles a non-empty queue may lose arbitration before a write is forced

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
clear_req  in  1  single-cycle pulse: invalidate whole BTB and drop queued updates
flush  in  1  mispredict flush: kill the lookup response due next cycle
lk_valid  in  1  fetch lookup request
lk_pc  in  W_PC  lookup PC tag
lk_ready  out  1  lookup accepted this cycle when lk_valid && lk_ready
lk_resp_valid  out  1  registered lookup response strobe
lk_hit  out  1  registered hit flag
lk_bta  out  W_BTA  registered predicted target; 0 on miss
up_valid  in  1  resolved-taken branch update request
up_pc  in  W_PC  update PC tag
up_bta  in  W_BTA  update target
up_ready  out  1  queue can accept (count < QDEPTH, not clearing)
btb_op  out  2  0=NOP, 1=LOOKUP, 2=WRITE, 3=CLEAR (combinational, this cycle)
btb_pc  out  W_PC  PC tag driven to BTB
btb_wbta  out  W_BTA  target driven to BTB on WRITE
btb_hit  in  1  BTB combinational hit for btb_pc
btb_rbta  in  W_BTA  BTB combinational target

Behaviour:
- Reset (reset=0, async): state=RUN, queue empty, starve=0. lk_resp_valid=0, lk_hit=0, lk_bta=0. btb_op=NOP, btb_pc=0, btb_wbta=0. lk_ready and up_ready still follow the rules below once reset releases.
- FSM states RUN, FORCE_WR, CLEAR.
- RUN: lk_ready=1.
  - Lookup accepted: btb_op=LOOKUP, btb_pc=lk_pc.
  - Otherwise, if the queue is non-empty: btb_op=WRITE with the head entry; pop at the edge.
  - starve increments (saturating) each cycle the queue is non-empty and no write issues; it resets on any write or when the queue is empty.
  - starve==STARVE_MAX → next state FORCE_WR.
- FORCE_WR: lk_ready=0; head entry written (btb_op=WRITE); starve←0; next state RUN.
- CLEAR: lk_ready=0, up_ready=0, btb_op=CLEAR for exactly one cycle; next state RUN.
- clear_req (any state, highest priority): queue emptied at the edge; next state CLEAR.
  - If a lookup is accepted in the same cycle, it completes normally.
  - Updates presented in that cycle are dropped (up_ready=0 when clear_req=1).
- Lookup latency is 1 cycle: accept at edge N, response registered at edge N+1.
  - lk_hit/lk_bta take queue-bypass data first; otherwise btb_hit/btb_rbta.
  - Bypass: any valid queue entry with pc==lk_pc → hit=1, bta=that entry.
  - An update enqueued in the same cycle is not bypassed.
- flush in cycle N suppresses the response due at N+1 (lk_resp_valid=0; lk_hit/lk_bta hold). Queue is unaffected.
- lk_resp_valid=0 in any cycle with no accepted lookup; lk_hit/lk_bta hold their last value.
- Enqueue on up_valid && up_ready:
  - Coalescing: if up_pc matches a valid entry not being popped this cycle, overwrite that entry's bta with no new slot.
  - Coalescing is allowed even when full (up_ready=1 then if a match exists).
  - Matching the head entry that is being popped → enqueue as a new entry.
- Simultaneous enqueue and pop: count unchanged, FIFO order kept; full queue with a pop still reports up_ready=1.
- Queue pointers wrap modulo QDEPTH; the count is the sole full/empty source.
- Reset mid-operation: queue contents lost, no WRITE issued afterwards.

Decomposition:
- Shared package btb_pkg: btb_op encodings (BTB_NOP/LOOKUP/WRITE/CLEAR), FSM state encodings, and the {pc, bta} update-entry layout, reused by BTB and pipeline.
- One sub-module btb_upd_queue: FIFO with coalesce-on-match and a parallel pc-compare bypass port.
- Arbitration and FSM stay in the top level.

Test Plan:
- Reset, queue write {pc=08, bta=00000011}, idle, lookup pc=08 → WRITE cycle, then resp_valid=1, hit=1, bta=00000011 one cycle after the lookup is accepted.
- Enqueue pc=12/bta=22, lookup pc=12 next cycle (continuous lookups) → hit=1, bta=00000022 via bypass before any WRITE.
- Continuous lk_valid with 1 queued entry, STARVE_MAX=3 → lk_ready drops in exactly one cycle (4th after enqueue), btb_op=WRITE there.
- Fill queue (QDEPTH=2), up_valid with a new pc → up_ready=0; same pc as tail with bta=99 → accepted, count stays 2, later WRITE carries 99.
- Lookup accepted with flush in the same cycle → lk_resp_valid=0 next cycle; next lookup without flush responds normally.
- 2 queued entries then clear_req → btb_op=CLEAR next cycle, lk_ready=0 that cycle, no WRITE ever issued for the dropped entries; async reset mid-queue → same with no CLEAR.
